// File: rtl/instr_fetch_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : instr_fetch_mem_pkg                                              |
// | Brief   : Shared defaults, NOP word, fetch status and clog2 helper.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package instr_fetch_mem_pkg;

    localparam int c_data_w_default = 16;
    localparam int c_depth_default  = 16;
    localparam int c_addr_w_default = 16;

    // Wide enough for any supported instruction width; consumers slice it.
    localparam logic [127:0] c_nop = '0;

    typedef enum logic [1:0] {
        FETCH_OK         = 2'd0,
        FETCH_OOR        = 2'd1,
        FETCH_MISALIGNED = 2'd2
    } fetch_status_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_mem_imem_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : imem_array                                                       |
// | Brief   : DEPTH x DATA_W instruction store, 1 sync read-first, 1 write.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module imem_array
    import instr_fetch_mem_pkg::*;
#(
    parameter int DATA_W = c_data_w_default,
    parameter int DEPTH  = c_depth_default
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [clog2(DEPTH)-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_rd_en,
    input  logic [clog2(DEPTH)-1:0]  i_rd_addr,
    output logic [DATA_W-1:0]        o_rd_data
);

    // Power-up contents are NOP; reset deliberately leaves them alone.
    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] r_rd_data = '0;

    // The read samples the array before this edge's write lands: read-first.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : instr_fetch_mem                                                  |
// | Brief   : Instruction fetch with range/alignment fault, stall and flush.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instr_fetch_mem
    import instr_fetch_mem_pkg::*;
#(
    parameter int DATA_W = c_data_w_default,
    parameter int DEPTH  = c_depth_default,
    parameter int ADDR_W = c_addr_w_default
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic [ADDR_W-1:0]        pc,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [clog2(DEPTH)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        instr,
    output logic                     instr_valid,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic                     fault,
    output logic [7:0]               fault_count
);

    localparam int unsigned c_bw    = DATA_W / 8;
    localparam int unsigned c_off_w = clog2(c_bw);
    localparam int unsigned c_aw    = clog2(DEPTH);
    localparam int unsigned c_limit = DEPTH * c_bw;

    logic [31:0]       w_pc_ext;
    fetch_status_e     w_status;
    logic              w_fault;
    logic [c_aw-1:0]   w_word_idx;
    logic              w_accept;
    logic              w_rd_en;
    logic [DATA_W-1:0] w_rd_data;

    logic              r_valid;
    logic [ADDR_W-1:0] r_pc;
    logic              r_fault;
    logic              r_nop;
    logic [7:0]        r_fault_count;

    assign w_pc_ext = 32'(pc);

    // Range is reported ahead of alignment; either way the result is a NOP.
    always_comb begin
        w_status = FETCH_OK;
        if (w_pc_ext >= c_limit) begin
            w_status = FETCH_OOR;
        end else if ((w_pc_ext & (c_bw - 1)) != 0) begin
            w_status = FETCH_MISALIGNED;
        end
    end

    assign w_fault    = (w_status != FETCH_OK);
    assign w_word_idx = c_aw'(w_pc_ext >> c_off_w);
    assign w_accept   = req & ~stall & ~flush & ~reset;
    assign w_rd_en    = w_accept & ~w_fault;

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_imem_array (
        .clk       (clk),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_word_idx),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_pc          <= '0;
            r_fault       <= 1'b0;
            r_nop         <= 1'b1;
            r_fault_count <= 8'd0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_valid <= req;
            if (req) begin
                r_pc    <= pc;
                r_fault <= w_fault;
                r_nop   <= w_fault;
                if (w_fault && (r_fault_count != 8'hFF)) begin
                    r_fault_count <= r_fault_count + 8'd1;
                end
            end
        end
    end

    // The array's read register only moves on good fetches, so it holds the
    // last instruction across stalls and idles; r_nop masks faults and reset.
    assign instr       = r_nop ? c_nop[DATA_W-1:0] : w_rd_data;
    assign instr_valid = r_valid;
    assign instr_pc    = r_pc;
    assign fault       = r_fault;
    assign fault_count = r_fault_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_instr_fetch_mem                                               |
// | Brief   : Directed vector table plus randomized run against a ref model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_mem;

    logic        clk;
    logic        reset, req, stall, flush, wr_en;
    logic [15:0] pc, wr_data, instr, instr_pc;
    logic [3:0]  wr_addr;
    logic        instr_valid, fault;
    logic [7:0]  fault_count;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: memory image plus the visible output registers.
    logic [15:0] m_mem [16];
    logic        m_valid, m_fault;
    logic [15:0] m_instr, m_pc;
    logic [7:0]  m_cnt;

    typedef struct {
        logic rst, rq, stl, fl, we;
        logic [3:0]  wa;
        logic [15:0] wd, p;
        logic ev;
        logic [15:0] ei, epc;
        logic ef;
        logic [7:0] ec;
    } vec_t;

    vec_t vecs [22];

    instr_fetch_mem u_dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .pc          (pc),
        .stall       (stall),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_pc    (instr_pc),
        .fault       (fault),
        .fault_count (fault_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, rq, stl, fl, we, input logic [3:0] wa,
                                input logic [15:0] wd, p, input logic ev,
                                input logic [15:0] ei, epc, input logic ef,
                                input logic [7:0] ec);
        vec_t v;
        v.rst = rst; v.rq = rq; v.stl = stl; v.fl = fl; v.we = we;
        v.wa = wa; v.wd = wd; v.p = p;
        v.ev = ev; v.ei = ei; v.epc = epc; v.ef = ef; v.ec = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check5(input string tag, input logic ev, input logic [15:0] ei,
                          input logic [15:0] epc, input logic ef, input logic [7:0] ec);
        check({tag, ".valid"}, 32'(instr_valid), 32'(ev));
        check({tag, ".instr"}, 32'(instr), 32'(ei));
        check({tag, ".pc"}, 32'(instr_pc), 32'(epc));
        check({tag, ".fault"}, 32'(fault), 32'(ef));
        check({tag, ".count"}, 32'(fault_count), 32'(ec));
    endtask

    // One clock of stimulus; the model advances by the rules, read before write.
    task automatic apply(input logic rs, rq, st, fl, we, input logic [3:0] wa,
                         input logic [15:0] wd, p);
        logic bad;
        reset = rs; req = rq; stall = st; flush = fl;
        wr_en = we; wr_addr = wa; wr_data = wd; pc = p;
        @(posedge clk);
        #1;
        if (rs) begin
            m_valid = 0; m_instr = 0; m_pc = 0; m_fault = 0; m_cnt = 0;
        end else if (fl) begin
            m_valid = 0;
        end else if (!st) begin
            m_valid = rq;
            if (rq) begin
                bad     = (p >= 16'd32) || (p % 2 != 0);
                m_pc    = p;
                m_fault = bad;
                m_instr = bad ? 16'h0000 : m_mem[p / 2];
                if (bad && m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
            end
        end
        if (we) m_mem[wa] = wd;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
        m_valid = 0; m_instr = 0; m_pc = 0; m_fault = 0; m_cnt = 0;
        reset = 1; req = 0; stall = 0; flush = 0; wr_en = 0;
        wr_addr = 0; wr_data = 0; pc = 0;

        //            rst rq st fl we wa  wd        pc     ev  instr     pc     f  cnt
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 16'h0000, 16'd0,  0, 16'h0000, 16'd0,  0, 8'd0);
        vecs[1]  = mk(0, 0, 0, 0, 1, 3, 16'hF201, 16'd0,  0, 16'h0000, 16'd0,  0, 8'd0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 0, 16'h0000, 16'd6,  1, 16'hF201, 16'd6,  0, 8'd0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 0, 16'h0000, 16'd32, 1, 16'h0000, 16'd32, 1, 8'd1);
        vecs[4]  = mk(0, 1, 0, 0, 0, 0, 16'h0000, 16'd7,  1, 16'h0000, 16'd7,  1, 8'd2);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'd0,  0, 16'h0000, 16'd7,  1, 8'd2);
        vecs[6]  = mk(0, 0, 0, 0, 1, 2, 16'h1111, 16'd0,  0, 16'h0000, 16'd7,  1, 8'd2);
        vecs[7]  = mk(0, 1, 0, 0, 0, 0, 16'h0000, 16'd4,  1, 16'h1111, 16'd4,  0, 8'd2);
        vecs[8]  = mk(0, 1, 1, 0, 0, 0, 16'h0000, 16'd8,  1, 16'h1111, 16'd4,  0, 8'd2);
        vecs[9]  = mk(0, 1, 1, 0, 0, 0, 16'h0000, 16'd8,  1, 16'h1111, 16'd4,  0, 8'd2);
        vecs[10] = mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'd8,  1, 16'h1111, 16'd4,  0, 8'd2);
        vecs[11] = mk(0, 1, 0, 0, 1, 2, 16'hAAAA, 16'd4,  1, 16'h1111, 16'd4,  0, 8'd2);
        vecs[12] = mk(0, 1, 0, 0, 0, 0, 16'h0000, 16'd4,  1, 16'hAAAA, 16'd4,  0, 8'd2);
        vecs[13] = mk(0, 1, 0, 1, 0, 0, 16'h0000, 16'd40, 0, 16'hAAAA, 16'd4,  0, 8'd2);
        vecs[14] = mk(0, 1, 1, 1, 0, 0, 16'h0000, 16'd6,  0, 16'hAAAA, 16'd4,  0, 8'd2);
        vecs[15] = mk(0, 1, 0, 0, 0, 0, 16'h0000, 16'd6,  1, 16'hF201, 16'd6,  0, 8'd2);
        vecs[16] = mk(1, 1, 0, 0, 0, 0, 16'h0000, 16'd4,  0, 16'h0000, 16'd0,  0, 8'd0);
        vecs[17] = mk(0, 1, 0, 0, 0, 0, 16'h0000, 16'd6,  1, 16'hF201, 16'd6,  0, 8'd0);
        vecs[18] = mk(1, 0, 0, 0, 1, 5, 16'hBEEF, 16'd0,  0, 16'h0000, 16'd0,  0, 8'd0);
        vecs[19] = mk(0, 1, 0, 0, 0, 0, 16'h0000, 16'd10, 1, 16'hBEEF, 16'd10, 0, 8'd0);
        vecs[20] = mk(0, 1, 0, 0, 0, 0, 16'h0000, 16'd30, 1, 16'h0000, 16'd30, 0, 8'd0);
        vecs[21] = mk(0, 1, 0, 0, 0, 0, 16'h0000, 16'd31, 1, 16'h0000, 16'd31, 1, 8'd1);

        for (int i = 0; i < 22; i++) begin
            apply(vecs[i].rst, vecs[i].rq, vecs[i].stl, vecs[i].fl, vecs[i].we,
                  vecs[i].wa, vecs[i].wd, vecs[i].p);
            check5($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].epc,
                   vecs[i].ef, vecs[i].ec);
        end

        // 300 faulted fetches, alternating misaligned and out-of-range.
        for (int k = 0; k < 300; k++) begin
            apply(0, 1, 0, 0, 0, 4'd0, 16'h0000,
                  (k % 2 != 0) ? 16'(2 * k + 1) : 16'(32 + 2 * (k % 50)));
        end
        check("saturate.count", 32'(fault_count), 32'd255);
        check5("saturate.model", m_valid, m_instr, m_pc, m_fault, m_cnt);

        for (int n = 0; n < 500; n++) begin
            apply(($urandom % 40) == 0, ($urandom % 4) != 0, ($urandom % 5) == 0,
                  ($urandom % 8) == 0, ($urandom % 3) == 0, 4'($urandom),
                  16'($urandom), 16'($urandom_range(0, 47)));
            check5($sformatf("rand%0d", n), m_valid, m_instr, m_pc, m_fault, m_cnt);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
